// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared widths, reset constants and the wrapping-increment
//                helper for the FIFO pointer/flag controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int unsigned C_PTR_RST = 0;
    localparam int unsigned C_CNT_RST = 0;

    // The count must be able to hold MEM_SIZE itself, hence one bit wider.
    function automatic int cnt_width(input int ptr_l);
        return ptr_l + 1;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned ptr,
                                             input int unsigned mem_size);
        return (ptr == mem_size - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_wrap.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr_wrap
//  Description : Registered pointer that advances on enable and wraps from
//                MEM_SIZE-1 to 0; synchronous active-high reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter int MEM_SIZE = 4,
    parameter int PTR_L    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [PTR_L-1:0] o_ptr
);

    logic [PTR_L-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= PTR_L'(C_PTR_RST);
        end else if (i_en) begin
            r_ptr <= PTR_L'(wrap_inc(32'(r_ptr), $unsigned(MEM_SIZE)));
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr_ctrl
//  Description : FIFO pointer, occupancy and flag controller with sticky
//                overflow/underflow errors and empty-FIFO bypass indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int MEM_SIZE = 4,
    parameter int PTR_L    = 3,
    parameter int CNT_L    = cnt_width(PTR_L)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_wr,
    input  logic             fifo_rd,
    input  logic [CNT_L-1:0] thr_high,
    input  logic [CNT_L-1:0] thr_low,
    input  logic             err_clr,
    output logic             push,
    output logic             pop,
    output logic             bypass,
    output logic [PTR_L-1:0] wr_ptr,
    output logic [PTR_L-1:0] rd_ptr,
    output logic [CNT_L-1:0] fifo_count,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam logic [CNT_L-1:0] c_cnt_max = CNT_L'(MEM_SIZE);
    localparam logic [CNT_L-1:0] c_cnt_one = CNT_L'(1);

    logic [CNT_L-1:0] r_count;
    logic             r_ovf;
    logic             r_udf;
    logic             w_full;
    logic             w_empty;
    logic             w_ovf_set;
    logic             w_udf_set;

    assign w_full  = (r_count == c_cnt_max);
    assign w_empty = (r_count == CNT_L'(C_CNT_RST));

    // A simultaneous read frees the slot (full) or supplies the data (empty),
    // so the opposing request is honoured in those corners.
    assign push   = !reset & fifo_wr & (!w_full  | fifo_rd);
    assign pop    = !reset & fifo_rd & (!w_empty | fifo_wr);
    assign bypass = !reset & w_empty & fifo_wr & fifo_rd;

    assign w_ovf_set = fifo_wr & w_full  & !fifo_rd;
    assign w_udf_set = fifo_rd & w_empty & !fifo_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= CNT_L'(C_CNT_RST);
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (push && !pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (pop && !push) begin
                r_count <= r_count - c_cnt_one;
            end
            // Set takes precedence over clear within the same cycle.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_set) begin
                r_udf <= 1'b1;
            end else if (err_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

    fifo_ptr_wrap #(
        .MEM_SIZE (MEM_SIZE),
        .PTR_L    (PTR_L)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .i_en  (push),
        .o_ptr (wr_ptr)
    );

    fifo_ptr_wrap #(
        .MEM_SIZE (MEM_SIZE),
        .PTR_L    (PTR_L)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .i_en  (pop),
        .o_ptr (rd_ptr)
    );

    assign fifo_count    = r_count;
    assign fifo_full     = w_full;
    assign fifo_empty    = w_empty;
    assign almost_full   = (r_count >= thr_high);
    assign almost_empty  = (r_count <= thr_low);
    assign overflow_err  = r_ovf;
    assign underflow_err = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ptr_ctrl
//  Description : Directed plus randomized self-checking bench for
//                fifo_ptr_ctrl against an occupancy/modulo reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ptr_ctrl;

    localparam int MEM   = 4;
    localparam int PTR_L = 3;
    localparam int CNT_L = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             fifo_wr = 1'b0;
    logic             fifo_rd = 1'b0;
    logic [CNT_L-1:0] thr_high = 4'd3;
    logic [CNT_L-1:0] thr_low = 4'd1;
    logic             err_clr = 1'b0;
    logic             push, pop, bypass;
    logic [PTR_L-1:0] wr_ptr, rd_ptr;
    logic [CNT_L-1:0] fifo_count;
    logic             fifo_full, fifo_empty, almost_full, almost_empty;
    logic             overflow_err, underflow_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: occupancy and pointers as plain integers.
    int m_cnt = 0;
    int m_wp  = 0;
    int m_rp  = 0;
    int m_ovf = 0;
    int m_udf = 0;

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(.MEM_SIZE(MEM), .PTR_L(PTR_L), .CNT_L(CNT_L)) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_wr       (fifo_wr),
        .fifo_rd       (fifo_rd),
        .thr_high      (thr_high),
        .thr_low       (thr_low),
        .err_clr       (err_clr),
        .push          (push),
        .pop           (pop),
        .bypass        (bypass),
        .wr_ptr        (wr_ptr),
        .rd_ptr        (rd_ptr),
        .fifo_count    (fifo_count),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        check("wr_ptr",        32'(wr_ptr),        32'(m_wp));
        check("rd_ptr",        32'(rd_ptr),        32'(m_rp));
        check("fifo_count",    32'(fifo_count),    32'(m_cnt));
        check("fifo_full",     32'(fifo_full),     32'(m_cnt == MEM));
        check("fifo_empty",    32'(fifo_empty),    32'(m_cnt == 0));
        check("almost_full",   32'(almost_full),   32'(m_cnt >= int'(thr_high)));
        check("almost_empty",  32'(almost_empty),  32'(m_cnt <= int'(thr_low)));
        check("overflow_err",  32'(overflow_err),  32'(m_ovf));
        check("underflow_err", 32'(underflow_err), 32'(m_udf));
    endtask

    // One clock cycle: drive, check strobes against the model, clock, update
    // the model, then check the registered state just after the edge.
    task automatic cycle(input logic wr, input logic rd, input logic clr, input logic rst);
        bit full, empty, e_push, e_pop, e_byp;
        fifo_wr = wr;
        fifo_rd = rd;
        err_clr = clr;
        reset   = rst;
        #1;
        full   = (m_cnt == MEM);
        empty  = (m_cnt == 0);
        e_push = !rst && wr && (!full || rd);
        e_pop  = !rst && rd && (!empty || wr);
        e_byp  = !rst && empty && wr && rd;
        check("push",   32'(push),   32'(e_push));
        check("pop",    32'(pop),    32'(e_pop));
        check("bypass", 32'(bypass), 32'(e_byp));
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (e_push) m_wp = (m_wp + 1) % MEM;
            if (e_pop)  m_rp = (m_rp + 1) % MEM;
            m_cnt = m_cnt + int'(e_push) - int'(e_pop);
            if (wr && full && !rd)       m_ovf = 1;
            else if (clr)                m_ovf = 0;
            if (rd && empty && !wr)      m_udf = 1;
            else if (clr)                m_udf = 0;
        end
        #1;
        check_state();
    endtask

    initial begin
        // First reset edge: registers are unknown before it, only strobes checked.
        reset = 1'b1; fifo_wr = 1'b1; fifo_rd = 1'b1;
        #1;
        check("rst_push",   32'(push),   32'd0);
        check("rst_pop",    32'(pop),    32'd0);
        check("rst_bypass", 32'(bypass), 32'd0);
        @(posedge clk);
        #1;
        cycle(1, 1, 0, 1);
        check("post_rst_empty", 32'(fifo_empty), 32'd1);
        check("post_rst_count", 32'(fifo_count), 32'd0);

        // Fill to full, then one overflowing write.
        repeat (4) cycle(1, 0, 0, 0);
        check("fill_full",  32'(fifo_full), 32'd1);
        check("fill_wrptr", 32'(wr_ptr),    32'd0);
        cycle(1, 0, 0, 0);
        check("ovf_set",   32'(overflow_err), 32'd1);
        check("ovf_count", 32'(fifo_count),   32'd4);
        check("ovf_wrptr", 32'(wr_ptr),       32'd0);

        // Simultaneous read/write while full.
        repeat (2) cycle(1, 1, 0, 0);
        check("full_rw_count", 32'(fifo_count), 32'd4);
        check("full_rw_rdptr", 32'(rd_ptr),     32'd2);
        check("full_rw_wrptr", 32'(wr_ptr),     32'd2);

        // Bypass on empty, then underflowing read.
        cycle(0, 0, 0, 1);
        thr_high = 4'd3; thr_low = 4'd1;
        cycle(1, 1, 0, 0);
        check("byp_count", 32'(fifo_count), 32'd0);
        check("byp_ptrs",  32'({wr_ptr, rd_ptr}), 32'({3'd1, 3'd1}));
        cycle(0, 1, 0, 0);
        check("udf_set",   32'(underflow_err), 32'd1);
        check("udf_rdptr", 32'(rd_ptr),        32'd1);

        // Almost-full / almost-empty thresholds while filling from empty.
        cycle(0, 0, 1, 0);
        check("clr_udf", 32'(underflow_err), 32'd0);
        cycle(1, 0, 0, 0);
        check("ae_cnt1", 32'({almost_empty, almost_full}), 32'b10);
        cycle(1, 0, 0, 0);
        check("ae_cnt2", 32'({almost_empty, almost_full}), 32'b00);
        cycle(1, 0, 0, 0);
        check("af_cnt3", 32'(almost_full), 32'd1);

        // Reset clears count, pointers and a pending overflow.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("pre_rst_count", 32'(fifo_count),   32'd2);
        check("pre_rst_ovf",   32'(overflow_err), 32'd1);
        cycle(0, 0, 0, 1);
        check("rst_count", 32'(fifo_count),       32'd0);
        check("rst_ptrs",  32'({wr_ptr, rd_ptr}), 32'd0);
        check("rst_ovf",   32'(overflow_err),     32'd0);

        // Set wins over clear in the same cycle.
        repeat (4) cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        check("set_wins", 32'(overflow_err), 32'd1);
        cycle(0, 0, 1, 0);
        check("clr_ovf", 32'(overflow_err), 32'd0);

        // Zero high threshold keeps almost_full asserted even when empty.
        cycle(0, 0, 0, 1);
        thr_high = 4'd0;
        #1;
        check("thr0_af", 32'(almost_full), 32'd1);

        // Randomized traffic with moving thresholds.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) thr_high = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) thr_low  = 4'($urandom_range(0, 5));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
